sram_bist_march_ctrl: RTL
=========================

SRAM_BIST_MARCH_CTRL -- requirements
Module: sram_bist_march_ctrl

Interface
REQ-001 SHALL have parameter P_DATA_WIDTH, default 24: SRAM word width.
REQ-002 SHALL have parameter P_ADDR_WIDTH, default 14: SRAM address width; depth 2**P_ADDR_WIDTH.
REQ-003 SHALL have port A_CLK, input, 1: the single clock; it also drives the SRAM A_BIST_CLK.
REQ-004 SHALL have port A_RST_N, input, 1: asynchronous, active-low reset.
REQ-005 SHALL have port A_START, input, 1: one-cycle test request.
REQ-006 SHALL have port A_BUSY, output, 1: test in progress.
REQ-007 SHALL have port A_DONE, output, 1: sticky test-complete flag.
REQ-008 SHALL have port A_FAIL, output, 1: sticky mismatch flag.
REQ-009 SHALL have port A_FAIL_ADDR, output, P_ADDR_WIDTH: address of the first mismatch.
REQ-010 SHALL have port A_FAIL_ELEM, output, 3: March element (0-5) of the first mismatch.
REQ-011 SHALL have ports A_BIST_EN, A_BIST_MEN, A_BIST_WEN, A_BIST_REN, outputs, 1 each: drive the SRAM BIST port.
REQ-012 SHALL have ports A_BIST_ADDR (P_ADDR_WIDTH), A_BIST_DIN and A_BIST_BM (P_DATA_WIDTH each), outputs: drive the SRAM BIST port.
REQ-013 SHALL have port A_BIST_DOUT, input, P_DATA_WIDTH: SRAM A_DOUT.

Function
REQ-014 SHALL run March C- with these elements:
- 0: up, w0
- 1: up, (r0, w1)
- 2: up, (r1, w0)
- 3: down, (r0, w1)
- 4: down, (r1, w0)
- 5: up, r0
REQ-015 SHALL use backgrounds "0" = all zeros and "1" = all ones, with A_BIST_BM all ones on every operation.
REQ-016 SHALL register all SRAM-side outputs and issue one operation per cycle.
REQ-017 SHALL drive each operation as follows:
- write: MEN=1, WEN=1, REN=0.
- read: MEN=1, WEN=0, REN=1.
- cycle with no operation: MEN=WEN=REN=0.
REQ-018 SHALL implement states IDLE, RUN, DRAIN, DONE with these transitions:
- IDLE/DONE to RUN: on A_START.
- RUN to DRAIN: after the last element-5 read.
- DRAIN to DONE: after one cycle.
- Abort to DONE: on a mismatch when SRAM_BIST_FAIL_CNT_EN is undefined.
REQ-019 SHALL hold A_BIST_EN=1 exactly while A_BUSY=1, and A_BUSY=1 in RUN and DRAIN.
REQ-020 SHALL compare the read data in the cycle after the read is issued, against a pipelined expected value, element number and address.
REQ-021 SHALL hold A_BUSY high for exactly 10*2**P_ADDR_WIDTH+1 cycles on a clean run; A_BUSY falls and A_DONE rises on the same edge.
REQ-022 SHALL wrap the address counter at 2**P_ADDR_WIDTH-1 (up) and at 0 (down), then advance to the next element.
REQ-023 SHALL ignore A_START while A_BUSY=1.
REQ-024 SHALL, on A_START in IDLE or DONE, clear A_DONE, A_FAIL, A_FAIL_ADDR and A_FAIL_ELEM in the cycle A_BUSY rises.
REQ-025 SHALL capture A_FAIL_ADDR and A_FAIL_ELEM on the first mismatch only, and set A_FAIL the same cycle.

Reset
REQ-026 SHALL force all of the following to 0 immediately on A_RST_N low, including mid-test, and enter IDLE: every output, state, counters and compare pipeline.
REQ-027 SHALL release SRAM control (A_BIST_EN=0) in the same reset assertion, so no partial write is issued after reset.

Configuration
REQ-028 SHALL use macro SRAM_BIST_FAIL_CNT_EN, which selects the behaviour below:
- Defined: adds output port A_FAIL_CNT (16 bits), a saturating count of mismatching reads; the test always runs to completion.
- Undefined: the port is absent, and the first mismatch goes to DONE with A_BIST_EN low on the next cycle.

Structure
REQ-029 SHALL place the following in shared package sram_bist_pkg: state enum, element index type, op enum (NOP/RD/WR), and per-element direction/expected-data constants.
REQ-030 SHALL contain one sub-module, sram_bist_addr_gen: up/down address counter with load, step and terminal-count output.

Verification (bench: team 1P SRAM behavioral model on BIST port; P_ADDR_WIDTH=4, P_DATA_WIDTH=8)
REQ-031 SHALL verify clean run: A_START pulse -> A_BUSY for 161 cycles, then A_DONE=1, A_FAIL=0.
REQ-032 SHALL verify stuck-at-1: force A_BIST_DOUT bit 3 =1 on reads of addr 5 -> A_FAIL=1, A_FAIL_ADDR=5, A_FAIL_ELEM=1, A_DONE=1.
REQ-033 SHALL verify reset mid-test: A_RST_N low at cycle 40 of RUN -> all outputs 0 immediately; a new A_START runs a clean 161-cycle test.
REQ-034 SHALL verify the start rules:
- A_START at busy cycle 10 -> ignored, A_BUSY length unchanged.
- A_START while A_DONE=1 with A_FAIL=1 -> both flags clear and a new test begins.
REQ-035 SHALL verify the counter build: with SRAM_BIST_FAIL_CNT_EN, force bit 0 of every read =1 -> the test runs the full 161 cycles, A_FAIL_CNT=48 (element 2 and 4 reads pass), A_FAIL_ELEM=1, A_FAIL_ADDR=0.

Source files
------------

// File: rtl/sram_bist_pkg.sv
// Shared types and March C- element tables for the SRAM BIST controller.
package sram_bist_pkg;

  typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_DRAIN, ST_DONE} state_e;
  typedef enum logic [1:0] {OP_NOP, OP_RD, OP_WR} op_e;
  typedef logic [2:0] elem_t;

  // Element 6 is the "all ops issued" marker, not a real element.
  localparam elem_t ELEM_END   = 3'd6;
  localparam int    FAIL_CNT_W = 16;

  // Bit i describes March element i (bits 6/7 are the end marker).
  localparam logic [7:0] ELEM_DOWN   = 8'b0001_1000;  // elements 3,4 walk down
  localparam logic [7:0] ELEM_HAS_RD = 8'b0011_1110;  // elements 1..5 read
  localparam logic [7:0] ELEM_HAS_WR = 8'b0001_1111;  // elements 0..4 write
  localparam logic [7:0] ELEM_RD_BG  = 8'b0001_0100;  // r1 in elements 2,4
  localparam logic [7:0] ELEM_WR_BG  = 8'b0000_1010;  // w1 in elements 1,3

  // Two-op elements read in phase 0 and write in phase 1.
  function automatic op_e elem_op(elem_t e, logic ph);
    if (ELEM_HAS_RD[e] && !ph) return OP_RD;
    return OP_WR;
  endfunction

  // True when the op in this phase is the last one at the current address.
  function automatic logic elem_last_op(elem_t e, logic ph);
    return ph || !(ELEM_HAS_RD[e] && ELEM_HAS_WR[e]);
  endfunction

endpackage

// File: rtl/sram_bist_addr_gen.sv
// Up/down address counter with load, step and terminal-count output.
module sram_bist_addr_gen #(
  parameter int P_ADDR_WIDTH = 14
) (
  input  logic                    A_CLK,
  input  logic                    A_RST_N,
  input  logic                    load,
  input  logic                    load_down,
  input  logic                    step,
  input  logic                    down,
  output logic [P_ADDR_WIDTH-1:0] addr,
  output logic                    tc
);

  // Load picks the start end of the range; step walks in the current direction.
  always_ff @(posedge A_CLK or negedge A_RST_N) begin
    if (!A_RST_N)  addr <= '0;
    else if (load) addr <= load_down ? '1 : '0;
    else if (step) addr <= down ? addr - 1'b1 : addr + 1'b1;
  end

  assign tc = down ? (addr == '0) : (addr == '1);

endmodule

// File: rtl/sram_bist_march_ctrl.sv
// March C- BIST controller for a single-port SRAM BIST port.
// Optional macro SRAM_BIST_FAIL_CNT_EN: adds A_FAIL_CNT and runs to
// completion on mismatches; without it the first mismatch aborts to DONE.
module sram_bist_march_ctrl
  import sram_bist_pkg::*;
#(
  parameter int P_DATA_WIDTH = 24,
  parameter int P_ADDR_WIDTH = 14
) (
  input  logic                    A_CLK,
  input  logic                    A_RST_N,
  input  logic                    A_START,
  output logic                    A_BUSY,
  output logic                    A_DONE,
  output logic                    A_FAIL,
  output logic [P_ADDR_WIDTH-1:0] A_FAIL_ADDR,
  output logic [2:0]              A_FAIL_ELEM,
`ifdef SRAM_BIST_FAIL_CNT_EN
  output logic [FAIL_CNT_W-1:0]   A_FAIL_CNT,
`endif
  output logic                    A_BIST_EN,
  output logic                    A_BIST_MEN,
  output logic                    A_BIST_WEN,
  output logic                    A_BIST_REN,
  output logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR,
  output logic [P_DATA_WIDTH-1:0] A_BIST_DIN,
  output logic [P_DATA_WIDTH-1:0] A_BIST_BM,
  input  logic [P_DATA_WIDTH-1:0] A_BIST_DOUT
);

  state_e state_q, state_d;
  elem_t  elem_q, elem_d;
  logic   phase_q, phase_d;
  logic   issue, start_acc, run_d, mis;
  logic   ag_load, ag_step, ag_tc;
  logic [P_ADDR_WIDTH-1:0] ag_addr;
  op_e    op_cur;

  // Compare pipeline: stage 0 tracks the issued read, stage 1 lines up with DOUT.
  logic [1:0]                   vld_pipe;
  logic [1:0]                   exp_pipe;
  logic [1:0][2:0]              elem_pipe;
  logic [1:0][P_ADDR_WIDTH-1:0] addr_pipe;

  assign op_cur = elem_op(elem_q, phase_q);
  assign run_d  = (state_d == ST_RUN) || (state_d == ST_DRAIN);
  assign mis    = vld_pipe[1] && (A_BIST_DOUT != {P_DATA_WIDTH{exp_pipe[1]}});

  sram_bist_addr_gen #(.P_ADDR_WIDTH(P_ADDR_WIDTH)) u_addr_gen (
    .A_CLK     (A_CLK),
    .A_RST_N   (A_RST_N),
    .load      (ag_load),
    .load_down (ELEM_DOWN[elem_d]),
    .step      (ag_step),
    .down      (ELEM_DOWN[elem_q]),
    .addr      (ag_addr),
    .tc        (ag_tc)
  );

  // Next state, op issue and element/phase/address sequencing.
  always_comb begin
    state_d   = state_q;
    elem_d    = elem_q;
    phase_d   = phase_q;
    issue     = 1'b0;
    start_acc = 1'b0;
    ag_load   = 1'b0;
    ag_step   = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE: if (A_START) begin
        state_d   = ST_RUN;
        start_acc = 1'b1;
        issue     = 1'b1;
      end
      ST_RUN:   if (elem_q == ELEM_END) state_d = ST_DRAIN;
                else                    issue   = 1'b1;
      ST_DRAIN: state_d = ST_DONE;
      default:  state_d = ST_IDLE;
    endcase
`ifndef SRAM_BIST_FAIL_CNT_EN
    // mis can only be set while busy, so this aborts RUN/DRAIN only.
    if (mis) begin
      state_d = ST_DONE;
      issue   = 1'b0;
    end
`endif
    if (issue) begin
      if (elem_last_op(elem_q, phase_q)) begin
        phase_d = 1'b0;
        if (ag_tc) begin
          elem_d  = elem_q + 3'd1;
          ag_load = 1'b1;
        end else begin
          ag_step = 1'b1;
        end
      end else begin
        phase_d = 1'b1;
      end
    end else if (state_d == ST_DONE) begin
      // Park the sequencer at element 0, address 0 ready for the next start.
      elem_d  = '0;
      phase_d = 1'b0;
      ag_load = 1'b1;
    end
  end

  // State and sequencer registers.
  always_ff @(posedge A_CLK or negedge A_RST_N) begin
    if (!A_RST_N) begin
      state_q <= ST_IDLE;
      elem_q  <= '0;
      phase_q <= 1'b0;
    end else begin
      state_q <= state_d;
      elem_q  <= elem_d;
      phase_q <= phase_d;
    end
  end

  // Registered SRAM port: one op per cycle, NOP drives everything low.
  always_ff @(posedge A_CLK or negedge A_RST_N) begin
    if (!A_RST_N) begin
      A_BUSY      <= 1'b0;
      A_BIST_EN   <= 1'b0;
      A_BIST_MEN  <= 1'b0;
      A_BIST_WEN  <= 1'b0;
      A_BIST_REN  <= 1'b0;
      A_BIST_ADDR <= '0;
      A_BIST_DIN  <= '0;
      A_BIST_BM   <= '0;
    end else begin
      A_BUSY      <= run_d;
      A_BIST_EN   <= run_d;
      A_BIST_MEN  <= issue;
      A_BIST_WEN  <= issue && (op_cur == OP_WR);
      A_BIST_REN  <= issue && (op_cur == OP_RD);
      A_BIST_ADDR <= issue ? ag_addr : '0;
      A_BIST_DIN  <= (issue && op_cur == OP_WR && ELEM_WR_BG[elem_q]) ? '1 : '0;
      A_BIST_BM   <= issue ? '1 : '0;
    end
  end

  // Read-compare pipeline; flushed whenever the test is not running.
  always_ff @(posedge A_CLK or negedge A_RST_N) begin
    if (!A_RST_N) begin
      vld_pipe  <= '0;
      exp_pipe  <= '0;
      elem_pipe <= '0;
      addr_pipe <= '0;
    end else begin
      vld_pipe  <= run_d ? {vld_pipe[0], issue && (op_cur == OP_RD)} : 2'b00;
      exp_pipe  <= {exp_pipe[0], ELEM_RD_BG[elem_q]};
      elem_pipe <= {elem_pipe[0], elem_q};
      addr_pipe <= {addr_pipe[0], ag_addr};
    end
  end

  // Sticky result flags; first mismatch wins, all cleared on an accepted start.
  always_ff @(posedge A_CLK or negedge A_RST_N) begin
    if (!A_RST_N) begin
      A_DONE      <= 1'b0;
      A_FAIL      <= 1'b0;
      A_FAIL_ADDR <= '0;
      A_FAIL_ELEM <= '0;
    end else if (start_acc) begin
      A_DONE      <= 1'b0;
      A_FAIL      <= 1'b0;
      A_FAIL_ADDR <= '0;
      A_FAIL_ELEM <= '0;
    end else begin
      if (state_d == ST_DONE && state_q != ST_DONE) A_DONE <= 1'b1;
      if (mis && !A_FAIL) begin
        A_FAIL      <= 1'b1;
        A_FAIL_ADDR <= addr_pipe[1];
        A_FAIL_ELEM <= elem_pipe[1];
      end
    end
  end

`ifdef SRAM_BIST_FAIL_CNT_EN
  // Saturating count of mismatching reads.
  always_ff @(posedge A_CLK or negedge A_RST_N) begin
    if (!A_RST_N)                 A_FAIL_CNT <= '0;
    else if (start_acc)           A_FAIL_CNT <= '0;
    else if (mis && A_FAIL_CNT != '1) A_FAIL_CNT <= A_FAIL_CNT + 1'b1;
  end
`endif

endmodule
